// File: rtl/sbox_iter.sv
// sbox_iter: iterative AES SubBytes / InvSubBytes engine.
// LANES byte-substitution units are time-shared over the 128-bit state, so one
// state takes 16/LANES cycles. The result is latched into a dedicated output
// register so that out_data keeps the previous result while the next state is
// being processed.
module sbox_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sbox_iter: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam int NSTEP = 16 / LANES;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Forward S-box; entry n is FWD[n].
  localparam logic [0:255][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box; entry n is INV[n].
  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              mode;
  logic [15:0][7:0]  work;
  logic [15:0][7:0]  next_work;
  logic [127:0]      out_q;
  logic [3:0]        base;
  logic [7:0]        lane_byte;

  // Byte k of the state (k=0 is bits 127:120) lives in packed slot 15-k.
  assign base = 4'(int'(cnt) * LANES);

  // Substitute the LANES bytes selected by the step counter, leave the rest.
  always_comb begin
    next_work = work;
    lane_byte = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_byte = work[4'd15 - (base + 4'(l))];
      next_work[4'd15 - (base + 4'(l))] = mode ? INV[lane_byte] : FWD[lane_byte];
    end
  end

  // Control FSM plus work/mode/result registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
      work  <= '0;
      out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            mode  <= inv;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          work <= next_work;
          if (cnt == LAST_STEP) begin
            out_q <= next_work;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_sbox_iter.sv
// tb_sbox_iter: drives one sbox_iter per legal LANES value (1,2,4,8,16) and
// compares every cycle against a transaction-level model whose S-box tables
// are derived from GF(2^8) arithmetic, plus literal known-answer checks.
module tb_sbox_iter;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]        rst;
  logic [NI-1:0]        in_valid;
  logic [NI-1:0]        in_ready;
  logic [NI-1:0]        inv;
  logic [NI-1:0]        out_valid;
  logic [NI-1:0]        out_ready;
  logic [NI-1:0]        busy;
  logic [NI-1:0][127:0] in_data;
  logic [NI-1:0][127:0] out_data;

  // Instance g uses LANES = 2**g.
  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      sbox_iter #(.LANES(1 << g)) u_dut (
        .clk       (clk),
        .rst       (rst[g]),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_data   (in_data[g]),
        .inv       (inv[g]),
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .out_data  (out_data[g]),
        .busy      (busy[g])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;

  logic [7:0]   ftab [256];
  logic [7:0]   itab [256];
  int           m_rem [NI] = '{default: -1};
  logic [127:0] m_res [NI] = '{default: '0};
  logic [127:0] m_out [NI] = '{default: '0};

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] S00 = 128'h63636363636363636363636363636363;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int k = 0; k < 254; k++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] subst(input logic [127:0] d, input logic md);
    logic [127:0] r = '0;
    logic [7:0]   v;
    for (int b = 0; b < 16; b++) begin
      v = d[127 - 8*b -: 8];
      r[127 - 8*b -: 8] = md ? itab[v] : ftab[v];
    end
    return r;
  endfunction

  task automatic buildTables();
    for (int n = 0; n < 256; n++) ftab[n] = affine(ginv(8'(n)));
    for (int n = 0; n < 256; n++) itab[ftab[n]] = 8'(n);
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [127:0] d, input logic iv, input logic ordy);
    in_valid[idx]  = v;
    in_data[idx]   = d;
    inv[idx]       = iv;
    out_ready[idx] = ordy;
  endtask

  task automatic runTxn(input int idx, input logic [127:0] d, input logic iv, input int expLat, input logic [127:0] expData);
    int lat = 0;
    applyStimulus(idx, 1'b1, d, iv, 1'b1);
    tick();
    in_valid[idx] = 1'b0;
    in_data[idx]  = ~d;
    inv[idx]      = ~iv;
    while (!out_valid[idx] && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("latency", idx, 128'(lat), 128'(expLat));
    checkOutput("result", idx, out_data[idx], expData);
    tick();
    checkOutput("in_ready after done", idx, 128'(in_ready[idx]), 128'(1));
  endtask

  // Per-cycle comparison against the model, then advance the model using the
  // inputs that the coming rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checkOutput("in_ready", i, 128'(in_ready[i]), 128'(m_rem[i] == -1));
        checkOutput("out_valid", i, 128'(out_valid[i]), 128'(m_rem[i] == 0));
        checkOutput("busy", i, 128'(busy[i]), 128'(m_rem[i] != -1));
        checkOutput("out_data", i, out_data[i], m_out[i]);
        if (rst[i]) begin
          m_rem[i] = -1;
          m_out[i] = '0;
        end else if (m_rem[i] == -1) begin
          if (in_valid[i]) begin
            m_rem[i] = 16 >> i;
            m_res[i] = subst(in_data[i], inv[i]);
          end
        end else if (m_rem[i] > 0) begin
          m_rem[i]--;
          if (m_rem[i] == 0) m_out[i] = m_res[i];
        end else if (out_ready[i]) begin
          m_rem[i] = -1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    rst       = '1;
    in_valid  = '0;
    inv       = '0;
    out_ready = '1;
    in_data   = '0;
    buildTables();

    checkOutput("model sbox(00)", 0, 128'(ftab[8'h00]), 128'h63);
    checkOutput("model sbox(53)", 0, 128'(ftab[8'h53]), 128'hed);
    checkOutput("model inv(63)", 0, 128'(itab[8'h63]), 128'h00);
    checkOutput("model fwd vector", 0, subst(PT, 1'b0), CT);

    repeat (3) tick();
    rst = '0;
    for (int i = 0; i < NI; i++) begin
      checkOutput("reset in_ready", i, 128'(in_ready[i]), 128'(1));
      checkOutput("reset out_valid", i, 128'(out_valid[i]), 128'(0));
      checkOutput("reset busy", i, 128'(busy[i]), 128'(0));
      checkOutput("reset out_data", i, out_data[i], 128'h0);
    end
    repeat (20) begin
      tick();
      for (int i = 0; i < NI; i++) checkOutput("idle out_valid", i, 128'(out_valid[i]), 128'(0));
    end

    runTxn(2, 128'h0, 1'b0, 4, S00);
    runTxn(0, PT, 1'b0, 16, CT);
    runTxn(4, CT, 1'b1, 1, PT);
    runTxn(1, CT, 1'b1, 8, PT);
    runTxn(3, PT, 1'b0, 2, CT);

    // Backpressure on the LANES=4 instance.
    applyStimulus(2, 1'b1, 128'h0, 1'b0, 1'b0);
    tick();
    in_valid[2] = 1'b0;
    lat = 0;
    while (!out_valid[2] && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("stall latency", 2, 128'(lat), 128'(4));
    repeat (10) begin
      in_valid[2] = 1'b1;
      in_data[2]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv[2]      = 1'($urandom_range(0, 1));
      tick();
      checkOutput("stall out_valid", 2, 128'(out_valid[2]), 128'(1));
      checkOutput("stall out_data", 2, out_data[2], S00);
      checkOutput("stall in_ready", 2, 128'(in_ready[2]), 128'(0));
    end
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    tick();
    checkOutput("release in_ready", 2, 128'(in_ready[2]), 128'(1));
    checkOutput("release out_valid", 2, 128'(out_valid[2]), 128'(0));
    checkOutput("release out_data", 2, out_data[2], S00);
    runTxn(2, S00, 1'b1, 4, 128'h0);

    // Reset while the LANES=4 instance is at step 2.
    applyStimulus(2, 1'b1, PT, 1'b0, 1'b1);
    tick();
    in_valid[2] = 1'b0;
    repeat (2) tick();
    checkOutput("mid-run busy", 2, 128'(busy[2]), 128'(1));
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    checkOutput("abort in_ready", 2, 128'(in_ready[2]), 128'(1));
    checkOutput("abort busy", 2, 128'(busy[2]), 128'(0));
    checkOutput("abort out_data", 2, out_data[2], 128'h0);
    repeat (8) begin
      tick();
      checkOutput("abort out_valid", 2, 128'(out_valid[2]), 128'(0));
    end
    runTxn(2, PT, 1'b0, 4, CT);

    // Random traffic on all instances, including stalls and occasional resets.
    repeat (800) begin
      for (int i = 0; i < NI; i++) begin
        rst[i] = ($urandom_range(0, 99) == 0);
        applyStimulus(i, 1'($urandom_range(0, 1)),
                      {$urandom(), $urandom(), $urandom(), $urandom()},
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
      tick();
    end
    rst       = '0;
    in_valid  = '0;
    out_ready = '1;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sbox_iter.md
# sbox_iter

Parametrised, iterative AES SubBytes / InvSubBytes engine for the encryption datapath. It replaces the fully parallel 16-instance 128-bit S-box layer with `LANES` substitution units time-shared over the 128-bit state. This trades latency for area, and adds inverse-mode support for the decryption path. It accepts one state per transaction over a valid/ready handshake and returns the substituted state.

## Interface
- `LANES`, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16. Any other value is a compile-time error.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: `in_data`/`inv` valid.
- `in_ready` output, 1 bit: block can accept a state.
- `in_data` input, 128 bits: state to substitute. Byte 0 is `in_data[127:120]`; byte 15 is `in_data[7:0]`.
- `inv` input, 1 bit: 0 selects the forward S-box, 1 selects the inverse S-box. Sampled with `in_data`.
- `out_valid` output, 1 bit: `out_data` holds a completed result.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_data` output, 128 bits: substituted state, with the same byte ordering as `in_data`.
- `busy` output, 1 bit: high in RUN or DONE.

## Operation
- Each lane is one byte-substitution unit. The forward path is the existing forward S-box table; the inverse path is an inverse table within this block. A registered mode bit selects between them.
- FSM states: IDLE, RUN, DONE. `NSTEP = 16/LANES`. The step counter `cnt` is `$clog2(NSTEP)` bits wide, with a minimum width of 1.
- IDLE:
  - `in_ready=1`.
  - On `in_valid&&in_ready`: capture `in_data` into the work register, capture `inv` into the mode register, set `cnt=0`, and go to RUN.
- RUN:
  - Each cycle, bytes `cnt*LANES` through `cnt*LANES+LANES-1` of the work register are substituted and written back in place. Other bytes are unchanged.
  - If `cnt==NSTEP-1`, go to DONE. Otherwise `cnt` increments.
- DONE:
  - `out_valid=1`; `out_data` is the work register.
  - On `out_ready`, go to IDLE.
  - `out_data` holds its value after the handshake until the next result overwrites it.
- Only one transaction is in flight. `in_ready=0` throughout RUN and DONE, and no new state is accepted in the cycle DONE exits.
- `in_valid` asserted outside IDLE is ignored. `in_data` and `inv` changes after acceptance do not affect the running transaction.
- Reset:
  - `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=128'h0, `cnt`=0, state IDLE.
  - Reset during RUN or DONE abandons the transaction. No `out_valid` is produced for it.

## Timing
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. They have no combinational path from any input.
- Acceptance edge is E0. RUN occupies cycles E0+1 through E0+NSTEP. `out_valid` rises after edge E0+NSTEP, i.e. `NSTEP` cycles after acceptance (16/8/4/2/1 for `LANES`=1/2/4/8/16).
- `out_ready` is held high at DONE entry: DONE lasts 1 cycle and `in_ready` returns the next cycle. Minimum transaction period is `NSTEP+2` cycles.
- `out_ready` low: `out_valid` and `out_data` stay stable indefinitely.
- `rst` has priority over any simultaneous handshake.

## Test plan
- Reset, then check outputs: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0. `out_valid` stays 0 for 20 cycles with `in_valid` low.
- `LANES`=4, `inv`=0, `in_data`=128'h0 -> after 4 cycles, `out_data`=128'h63636363636363636363636363636363.
- `LANES`=1, `inv`=0, `in_data`=00112233445566778899aabbccddeeff -> after 16 cycles, `out_data`=638293c31bfc33f5c4eeacea4bc12816.
- `LANES`=16 and `LANES`=2, `inv`=1, `in_data`=638293c31bfc33f5c4eeacea4bc12816 -> `out_data`=00112233445566778899aabbccddeeff, with latency 1 and 8 cycles respectively.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `out_valid` and `out_data` are stable and `in_valid` pulses are ignored. Release -> `in_ready`=1 the next cycle and the next state is processed correctly.
- Assert `rst` at RUN step 2 -> IDLE next cycle, no `out_valid`. A subsequent transaction produces the correct result.
